// File: rtl/elevator_car_if.sv
// Dispatcher <-> car bundle for one elevator car.
//   master : dispatcher side. Drives car_call / hall_assign / hold_door and
//            observes the car status.
//   slave  : car controller side.
// Signals:
//   car_call[FLOORS]    in-car buttons (level or pulse)
//   hall_assign[FLOORS] pick-ups assigned to this car
//   hold_door           door-open button
//   location[FLOOR_W]   current floor
//   direction           1 = UP, 0 = DOWN
//   moving              1 = MOVING, 0 = STOPPED
//   door_state[2]       0 = OPEN, 1 = OPENING, 2 = CLOSED, 3 = CLOSING
//   pending[FLOORS]     latched stop requests
//   inc / dec           one-cycle pulse when the car reaches the next floor
//   arrived             one-cycle pulse when the car reaches a stopping floor
//   idle                stopped, door closed, nothing pending
interface elevator_car_if #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
);
    logic [FLOORS-1:0]  car_call;
    logic [FLOORS-1:0]  hall_assign;
    logic               hold_door;
    logic [FLOOR_W-1:0] location;
    logic               direction;
    logic               moving;
    logic [1:0]         door_state;
    logic [FLOORS-1:0]  pending;
    logic               inc;
    logic               dec;
    logic               arrived;
    logic               idle;

    modport master (
        output car_call, hall_assign, hold_door,
        input  location, direction, moving, door_state, pending,
               inc, dec, arrived, idle
    );

    modport slave (
        input  car_call, hall_assign, hold_door,
        output location, direction, moving, door_state, pending,
               inc, dec, arrived, idle
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller for an N-floor building.
// Latches stop requests, runs a timed door cycle (opening / dwell / closing)
// with hold and reopen, and moves the car one floor per TRAVEL_TICKS cycles
// in a sweep: keep going while requests lie ahead, then reverse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    elevator_car_if.slave (calls in, car status out)
module elevator_car_ctrl #(
    parameter int FLOORS       = 8,
    parameter int FLOOR_W      = 3,
    parameter int DOOR_TICKS   = 4,
    parameter int TRAVEL_TICKS = 6,
    parameter int INIT_FLOOR   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    elevator_car_if.slave bus
);
    localparam int DT_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam int TT_W = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;

    localparam logic [DT_W-1:0]    DOOR_LOAD   = DT_W'(DOOR_TICKS - 1);
    localparam logic [TT_W-1:0]    TRAVEL_LOAD = TT_W'(TRAVEL_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOOR_W-1:0] RESET_FLOOR = FLOOR_W'(INIT_FLOOR);

    typedef enum logic [1:0] {
        DOOR_OPEN    = 2'd0,
        DOOR_OPENING = 2'd1,
        DOOR_CLOSED  = 2'd2,
        DOOR_CLOSING = 2'd3
    } door_e;

    typedef enum logic {
        STOPPED = 1'b0,
        MOVING  = 1'b1
    } move_e;

    door_e              door_q, door_d;
    move_e              move_q, move_d;
    logic [DT_W-1:0]    dtmr_q, dtmr_d;
    logic [TT_W-1:0]    ttmr_q, ttmr_d;
    logic [FLOOR_W-1:0] loc_q, loc_d;
    logic               dir_q, dir_d;
    logic [FLOORS-1:0]  pend_q, pend_d;

    logic [FLOORS-1:0]  calls_in;
    logic [FLOORS-1:0]  here_mask;
    logic               pend_here, call_here;
    logic               req_above, req_below;
    logic               pend_up1, pend_dn1;
    logic               req_above_up1, req_below_dn1;
    logic               dir_eff;
    logic               step, stop_here;

    assign calls_in = bus.car_call | bus.hall_assign;

    // Floor-relative views of the request vector, including the view from
    // the neighbouring floor the car is about to reach.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        here_mask     = '0;
        pend_here     = 1'b0;
        call_here     = 1'b0;
        req_above     = 1'b0;
        req_below     = 1'b0;
        pend_up1      = 1'b0;
        pend_dn1      = 1'b0;
        req_above_up1 = 1'b0;
        req_below_dn1 = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i == int'(loc_q)) begin
                here_mask[i] = 1'b1;
                pend_here    = pend_q[i];
                call_here    = calls_in[i];
            end
            if (i > int'(loc_q))     req_above     |= pend_q[i];
            if (i < int'(loc_q))     req_below     |= pend_q[i];
            if (i == int'(loc_q) + 1) pend_up1     = pend_q[i];
            if (i == int'(loc_q) - 1) pend_dn1     = pend_q[i];
            if (i > int'(loc_q) + 1) req_above_up1 |= pend_q[i];
            if (i < int'(loc_q) - 1) req_below_dn1 |= pend_q[i];
        end
    end

    // Direction the car would take if it started now: reverse only when
    // nothing lies ahead but something lies behind; the end floors force
    // the only possible direction.
    always_comb begin
        dir_eff = dir_q;
        if (dir_q && !req_above && req_below)
            dir_eff = 1'b0;
        else if (!dir_q && !req_below && req_above)
            dir_eff = 1'b1;
        if (loc_q == TOP_FLOOR)
            dir_eff = 1'b0;
        else if (loc_q == '0)
            dir_eff = 1'b1;
    end

    // Next-state logic for requests, door and movement.
    always_comb begin
        pend_d    = pend_q;
        door_d    = door_q;
        dtmr_d    = dtmr_q;
        move_d    = move_q;
        ttmr_d    = ttmr_q;
        loc_d     = loc_q;
        dir_d     = dir_q;
        step      = 1'b0;
        stop_here = 1'b0;

        // The current floor is served while the door is (being) opened, so a
        // call there is absorbed rather than latched.
        if (door_q == DOOR_OPENING || door_q == DOOR_OPEN)
            pend_d = (pend_q | calls_in) & ~here_mask;
        else
            pend_d = pend_q | calls_in;

        case (door_q)
            DOOR_CLOSED: begin
                if (move_q == STOPPED && pend_here) begin
                    door_d = DOOR_OPENING;
                    dtmr_d = DOOR_LOAD;
                end
            end
            DOOR_OPENING: begin
                if (dtmr_q == '0) begin
                    door_d = DOOR_OPEN;
                    dtmr_d = DOOR_LOAD;
                end else begin
                    dtmr_d = dtmr_q - 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (bus.hold_door || call_here) begin
                    dtmr_d = DOOR_LOAD;
                end else if (dtmr_q == '0) begin
                    door_d = DOOR_CLOSING;
                    dtmr_d = DOOR_LOAD;
                end else begin
                    dtmr_d = dtmr_q - 1'b1;
                end
            end
            DOOR_CLOSING: begin
                if (bus.hold_door || pend_here) begin
                    door_d = DOOR_OPENING;
                    dtmr_d = DOOR_LOAD;
                end else if (dtmr_q == '0) begin
                    door_d = DOOR_CLOSED;
                end else begin
                    dtmr_d = dtmr_q - 1'b1;
                end
            end
            default: door_d = DOOR_CLOSED;
        endcase

        case (move_q)
            STOPPED: begin
                if (door_q == DOOR_CLOSED) begin
                    dir_d = dir_eff;
                    if (!pend_here && ((dir_eff && req_above) || (!dir_eff && req_below))) begin
                        move_d = MOVING;
                        ttmr_d = TRAVEL_LOAD;
                    end
                end
            end
            MOVING: begin
                if (ttmr_q == '0) begin
                    // Stepping past the end floors cannot happen: a sweep only
                    // continues while a request lies further ahead.
                    step = 1'b1;
                    if (dir_q) begin
                        loc_d     = loc_q + 1'b1;
                        stop_here = pend_up1 || !req_above_up1;
                    end else begin
                        loc_d     = loc_q - 1'b1;
                        stop_here = pend_dn1 || !req_below_dn1;
                    end
                    if (stop_here)
                        move_d = STOPPED;
                    else
                        ttmr_d = TRAVEL_LOAD;
                end else begin
                    ttmr_d = ttmr_q - 1'b1;
                end
            end
            default: move_d = STOPPED;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            door_q <= DOOR_CLOSED;
            dtmr_q <= '0;
            move_q <= STOPPED;
            ttmr_q <= '0;
            loc_q  <= RESET_FLOOR;
            dir_q  <= 1'b1;
            pend_q <= '0;
        end else begin
            door_q <= door_d;
            dtmr_q <= dtmr_d;
            move_q <= move_d;
            ttmr_q <= ttmr_d;
            loc_q  <= loc_d;
            dir_q  <= dir_d;
            pend_q <= pend_d;
        end
    end

    assign bus.location   = loc_q;
    assign bus.direction  = dir_q;
    assign bus.moving     = (move_q == MOVING);
    assign bus.door_state = door_q;
    assign bus.pending    = pend_q;
    assign bus.inc        = step && dir_q;
    assign bus.dec        = step && !dir_q;
    assign bus.arrived    = step && stop_here;
    assign bus.idle       = (move_q == STOPPED) && (door_q == DOOR_CLOSED) && (pend_q == '0);
endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
- Parametrised single-car controller for an N-floor building; generalises the fixed 3-floor car model.
- Replaces random door and travel delays with deterministic tick counters.
- Adds door hold and door reopen (reversal on a new call at the current floor).
- One instance per car; a dispatcher drives hall_assign and consumes inc/dec/location.

Parameters:
- FLOORS, 8, number of floors, numbered 0..FLOORS-1 (FLOORS >= 2).
- FLOOR_W, 3, location width, must be >= clog2(FLOORS).
- DOOR_TICKS, 4, cycles spent in each of OPENING, OPEN (dwell) and CLOSING (>= 1).
- TRAVEL_TICKS, 6, cycles to travel one floor (>= 1).
- INIT_FLOOR, 0, floor loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- car_call  in  FLOORS  in-car buttons; one bit per floor, level or pulse.
- hall_assign  in  FLOORS  pick-ups assigned by the dispatcher.
- hold_door  in  1  door-open button.
- location  out  FLOOR_W  current floor.
- direction  out  1  1=UP, 0=DOWN.
- moving  out  1  1=MOVING, 0=STOPPED.
- door_state  out  2  0=OPEN, 1=OPENING, 2=CLOSED, 3=CLOSING.
- pending  out  FLOORS  latched stop requests.
- inc, dec  out  1  one-cycle pulse on the cycle the car reaches the next floor up/down.
- arrived  out  1  one-cycle pulse when the car reaches a floor at which it will stop.
- idle  out  1  STOPPED & CLOSED & pending==0 (combinational).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-travel or mid-door):
  - location=INIT_FLOOR, direction=UP, moving=0, door_state=CLOSED.
  - pending=0, timers=0, inc/dec/arrived=0.
- Derived signals: req_above = any pending bit above location; req_below = any pending bit below location.
- Request latch: next pending = (pending | car_call | hall_assign) & ~clr.
  - clr = onehot(location) while door_state is OPENING or OPEN.
  - Clear wins over a simultaneous set at that floor.
- Door FSM (a single timer counts DOOR_TICKS-1 down to 0 in each non-CLOSED state):
  - CLOSED -> OPENING when moving=0 and pending[location].
  - OPENING -> OPEN at timer 0.
  - OPEN -> CLOSING at timer 0. hold_door, or a new call at location, reloads the timer, so the door stays OPEN.
  - CLOSING -> CLOSED at timer 0.
  - CLOSING -> OPENING immediately if hold_door or pending[location]; the timer reloads.
  - The door never leaves CLOSED while moving=1.
- Direction update (only when moving=0 and door CLOSED, evaluated before the start decision in the same cycle):
  - UP with !req_above & req_below -> DOWN.
  - DOWN with !req_below & req_above -> UP.
  - At FLOORS-1, force DOWN; at floor 0, force UP.
- Movement FSM:
  - STOPPED -> MOVING when door CLOSED, !pending[location], and (UP & req_above or DOWN & req_below). Travel timer loads TRAVEL_TICKS-1.
  - MOVING: the timer decrements each cycle. On the cycle the timer reads 0, inc (UP) or dec (DOWN) is high and location updates by +/-1 at that edge.
  - After the step: if pending[new floor] or no further request in direction -> STOPPED, and arrived pulses in the same cycle as inc/dec. Otherwise stay MOVING and reload the timer (no STOPPED cycle in between).
  - Location never steps below 0 or above FLOORS-1; by construction req_above=0 at the top floor.
- Latency:
  - A call is visible in pending 1 cycle after it is sampled.
  - Movement starts 1 cycle after pending is visible, given the door is CLOSED.
- Arithmetic: location is unsigned FLOOR_W bits. Calls to floors >= FLOORS do not exist (the port is FLOORS wide).

Test Plan:
- Reset (FLOORS=8, INIT_FLOOR=0) -> location=0, direction=1, door_state=2, pending=0, idle=1. Assert rst_n low mid-travel at floor 2 -> same values in the same cycle.
- car_call[3] pulsed 1 cycle at location 0:
  - pending[3]=1, moving=1 two cycles after the pulse.
  - inc pulses 3 times, 6 cycles apart; arrived coincides with the 3rd.
  - location=3, door 2->1->0->3->2 with 4 cycles in each state; pending[3]=0 once OPENING.
- Stopped at floor 3 with direction UP: hall_assign bits 5 and 1 set together -> visits floor 5 first (2 inc), then direction=0 and 4 dec pulses to floor 1.
- hold_door held 10 cycles while OPEN -> door_state stays 0 throughout. Release -> CLOSING 4 cycles after the last hold, then CLOSED.
- car_call at the current floor during CLOSING -> next state OPENING; the door does not reach CLOSED.
- Call to floor 7 from floor 0 -> location=7 after 7 inc pulses, direction forced to 0. No inc pulse is ever generated at floor 7.
